// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the MU0 memory between the CPU (port A) and the
// debug/loader (port B); every access runs a fixed IDLE -> SERVE -> ACK sequence.
module mem_arbiter #(
    parameter bit PRIORITY_MODE = 1'b0
) (
    input  logic        clk,
    input  logic        resetN,
    // Handshake: a requester raises xReq with its fields stable and holds them
    // until xAck pulses for one cycle; xReq still high the cycle after xAck is a new request.
    input  logic        aReq,
    input  logic        aReadNotWrite,
    input  logic [15:0] aAddr,
    input  logic [15:0] aDataIn,
    output logic        aAck,
    output logic [15:0] aDataOut,
    input  logic        bReq,
    input  logic        bReadNotWrite,
    input  logic [15:0] bAddr,
    input  logic [15:0] bDataIn,
    output logic        bAck,
    output logic [15:0] bDataOut,
    input  logic        bLock,
    output logic        memRq,
    output logic        memReadNotWrite,
    output logic [15:0] memAddr,
    output logic [15:0] memDataIn,
    input  logic [15:0] memDataOut,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;
    localparam logic       OWN_A    = 1'b0;
    localparam logic       OWN_B    = 1'b1;

    logic [1:0]  state;
    logic        owner;
    logic        last_grant;
    logic        rnw_q;
    logic [15:0] addr_q;
    logic [15:0] data_q;
    logic        elig_a;
    logic        elig_b;
    logic        grant_b;

    always_comb begin
        elig_a = aReq && !bLock;
        elig_b = bReq;
        // On a tie, round-robin hands the grant to whichever port did not win last time.
        if (elig_a && elig_b) begin
            grant_b = PRIORITY_MODE ? 1'b0 : (last_grant == OWN_A);
        end else begin
            grant_b = elig_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state      <= ST_IDLE;
            owner      <= OWN_A;
            last_grant <= OWN_B;
            rnw_q      <= 1'b1;
            addr_q     <= 16'd0;
            data_q     <= 16'd0;
            aAck       <= 1'b0;
            bAck       <= 1'b0;
            aDataOut   <= 16'd0;
            bDataOut   <= 16'd0;
        end else begin
            aAck <= 1'b0;
            bAck <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (elig_a || elig_b) begin
                        owner      <= grant_b;
                        last_grant <= grant_b;
                        rnw_q      <= grant_b ? bReadNotWrite : aReadNotWrite;
                        addr_q     <= grant_b ? bAddr : aAddr;
                        data_q     <= grant_b ? bDataIn : aDataIn;
                        state      <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (owner == OWN_B) begin
                        bAck <= 1'b1;
                        if (rnw_q) bDataOut <= memDataOut;
                    end else begin
                        aAck <= 1'b1;
                        if (rnw_q) aDataOut <= memDataOut;
                    end
                    state <= ST_ACK;
                end
                ST_ACK:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // memRq is gated by resetN so a write in SERVE never lands during reset.
    always_comb begin
        memRq           = 1'b0;
        memReadNotWrite = 1'b1;
        memAddr         = 16'd0;
        memDataIn       = 16'd0;
        if (state == ST_SERVE) begin
            memRq           = resetN;
            memReadNotWrite = rnw_q;
            memAddr         = addr_q;
            memDataIn       = data_q;
        end
    end

    assign dbg_state = state;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single MU0 memory between the CPU datapath (port A) and the host debug/loader port (port B). It serialises requests into single-cycle memory accesses, returns registered read data and a one-cycle acknowledge to the winning requester, and lets the debug port lock the memory (halting CPU fetches) during program load or inspection. It sits between the CPU/loader and the memory block, driving the memory's memRq/readNotWrite/addr/dataIn and sampling its dataOut.

## Interface
- PRIORITY_MODE, 0, 0 = round-robin between A and B; 1 = fixed priority, A wins ties
- clk  input  1  system clock; all state updates on rising edge
- resetN  input  1  reset, synchronous, active-low
- aReq  input  1  port A request; held high with aReadNotWrite/aAddr/aDataIn stable until aAck
- aReadNotWrite  input  1  1 = read, 0 = write
- aAddr  input  16  word address
- aDataIn  input  16  write data
- aAck  output  1  one-cycle completion pulse
- aDataOut  output  16  registered read data, valid while aAck = 1
- bReq, bReadNotWrite, bAddr, bDataIn, bAck, bDataOut: same as port A, for port B
- bLock  input  1  while high, A is never granted; B retains exclusive access
- memRq  output  1  memory request
- memReadNotWrite  output  1  memory direction
- memAddr  output  16  memory address
- memDataIn  output  16  memory write data
- memDataOut  input  16  memory read data (combinational from memory)

## Operation
- States: IDLE, SERVE, ACK. Registers: state, owner (A/B), lastGrant (A/B), captured request fields, aDataOut, bDataOut, aAck, bAck.
- IDLE: eligible A = aReq && !bLock; eligible B = bReq. None -> stay IDLE. One -> grant it. Both -> PRIORITY_MODE 1: A; PRIORITY_MODE 0: the port not equal to lastGrant. On grant: latch owner's readNotWrite/addr/dataIn, set owner, lastGrant <= owner, go SERVE.
- SERVE: memRq = 1, mem* driven from latched fields. Read: owner's DataOut <= memDataOut at end of cycle. Write: memory writes at end of cycle; owner's DataOut unchanged. Owner's Ack <= 1. Go ACK.
- ACK: owner's Ack = 1 for exactly this cycle; requests ignored. Go IDLE.
- bLock asserted while A is in SERVE/ACK: A's transaction completes normally; lock affects only subsequent grants.
- Requester must deassert or change its request after Ack; a req still high in the cycle after Ack is a new request.
- Outside SERVE: memRq = 0, memReadNotWrite = 1, memAddr = 0, memDataIn = 0. memDataOut is ignored outside SERVE reads.
- memRq = (state == SERVE) && resetN, combinationally, so no write reaches memory at an edge where resetN is low.
- Reset: state IDLE, lastGrant B (A wins the first round-robin tie), aAck = bAck = 0, aDataOut = bDataOut = 0.
- Reset mid-transaction: no Ack is issued and the requester must reissue. A write in SERVE while resetN is low is suppressed.

## Timing
- Request seen in IDLE at cycle N; SERVE at N+1; Ack and DataOut valid at N+2; IDLE at N+3.
- Fixed three-cycle transaction; maximum throughput is one access every 3 cycles.
- Back-to-back: a pending loser is granted in the IDLE cycle immediately after the winner's ACK.
- Round-robin worst-case wait for one port under continuous contention: one foreign transaction (3 cycles).
- Acks are registered pulses; aAck and bAck are never high together.

## Test plan
- Reset, then A reads addr 5 of unwritten memory -> memRq high only in the SERVE cycle; aAck pulses 2 cycles after aReq; aDataOut = 16'h5555.
- B writes 16'h1234 to addr 3, then A reads addr 3 -> bAck pulses once, aDataOut = 16'h1234; bDataOut keeps its prior value after the write.
- PRIORITY_MODE 0, aReq and bReq held continuously with reissue after each Ack, for 4 grants -> grant order A,B,A,B with one Ack every 3 cycles.
- PRIORITY_MODE 1, same stimulus -> A granted every time; B granted only once aReq drops.
- bLock high with aReq and bReq both pending -> only bAck pulses; drop bLock -> A granted at the next IDLE.
- A writes 16'hFFFF to addr 7 with resetN pulled low during SERVE -> memRq low at that edge, no aAck; subsequent read of addr 7 returns 16'h5555.
